// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: central round-robin arbiter sharing one PCI FRAME/IRDY/AD bus
// among NUM_MASTERS initiators through active-low REQ/GNT pairs.
// Optional build macro: ARB_PARK_EN -- park the bus on master PARK_IDX while no
// REQ is low (default build: no parking, all GNT high when nobody requests).
//
// Handshake: a master pulls REQ[i] low to ask for the bus; the arbiter answers by
// driving GNT[i] low from a register (never more than one GNT bit low). The master
// may start a transaction (FRAME low) only while its GNT is low, and keeps REQ low
// for as long as it wants the bus. Bus ownership ends when FRAME and IRDY are both
// sampled high on the same edge.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS   = 4,
  parameter int GRANT_TIMEOUT = 16,
  parameter int PARK_IDX      = 0
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           FRAME,
  input  logic                           IRDY,
  input  logic [NUM_MASTERS-1:0]         REQ,
  output logic [NUM_MASTERS-1:0]         GNT,
  output logic [$clog2(NUM_MASTERS)-1:0] OWNER,
  output logic                           OWNER_VLD,
  output logic                           TIMEOUT_EV,
  output logic [1:0]                     dbg_state
);

  localparam int OW = $clog2(NUM_MASTERS);
  localparam int TW = $clog2(GRANT_TIMEOUT) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(GRANT_TIMEOUT - 1);
`ifdef ARB_PARK_EN
  localparam logic [OW-1:0] PARK_OWNER = OW'(PARK_IDX);
`endif

  // Reject configurations the arbiter was never meant to support.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || GRANT_TIMEOUT < 1 ||
      PARK_IDX < 0 || PARK_IDX >= NUM_MASTERS) begin : g_bad_cfg
    $error("pci_bus_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  state_t                 state_q, state_nx;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_nx;
  logic [OW-1:0]          owner_q, owner_nx;
  logic [OW-1:0]          rr_q, rr_nx;
  logic [OW-1:0]          winner;
  logic [TW-1:0]          timer_q, timer_nx;
  logic                   tev_q, tev_nx;
  logic                   win_found;
  logic                   bus_idle;
  logic                   other_req;
  logic                   park_hop;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [OW-1:0] idx);
    return NUM_MASTERS'(1) << idx;
  endfunction

  function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] idx);
    return (idx == OW'(NUM_MASTERS - 1)) ? '0 : idx + OW'(1);
  endfunction

  // Returns {found, index} of the first low request scanning upward from start.
  function automatic logic [OW:0] pick(input logic [NUM_MASTERS-1:0] req_n,
                                       input logic [OW-1:0] start);
    logic [OW-1:0] idx;
    logic [OW:0]   res;
    idx = start;
    res = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!res[OW] && !req_n[idx]) res = {1'b1, idx};
      idx = wrap_inc(idx);
    end
    return res;
  endfunction

  assign bus_idle             = FRAME & IRDY;
  assign {win_found, winner}  = pick(REQ, rr_q);
  assign other_req            = |(~REQ & ~onehot(owner_q));

  // Leaving a parked grant for a different master needs a turnaround clock.
  always_comb begin
    park_hop = 1'b0;
`ifdef ARB_PARK_EN
    park_hop = (gnt_q == ~onehot(PARK_OWNER)) && (winner != PARK_OWNER);
`endif
  end

  // Next-state, next-grant and bookkeeping for the arbitration FSM.
  always_comb begin
    state_nx = state_q;
    gnt_nx   = gnt_q;
    owner_nx = owner_q;
    rr_nx    = rr_q;
    timer_nx = timer_q;
    tev_nx   = 1'b0;
    case (state_q)
      IDLE, DEAD: begin
        if (win_found && park_hop) begin
          state_nx = DEAD;
          gnt_nx   = '1;
        end else if (win_found) begin
          state_nx = GRANT;
          gnt_nx   = ~onehot(winner);
          owner_nx = winner;
          rr_nx    = wrap_inc(winner);
          timer_nx = '0;
        end else begin
          state_nx = IDLE;
          gnt_nx   = '1;
`ifdef ARB_PARK_EN
          // A master leaving the bus passes through one all-high IDLE clock first.
          if (state_q == IDLE) begin
            gnt_nx   = ~onehot(PARK_OWNER);
            owner_nx = PARK_OWNER;
          end
`endif
        end
      end
      GRANT: begin
        if (!FRAME) begin
          state_nx = BUSY;
        end else if (REQ[owner_q]) begin
          state_nx = DEAD;
          gnt_nx   = '1;
        end else if (timer_q == T_LAST) begin
          state_nx = DEAD;
          gnt_nx   = '1;
          tev_nx   = 1'b1;
        end else if (timer_q != '1) begin
          timer_nx = timer_q + TW'(1);
        end
      end
      BUSY: begin
        if (bus_idle) begin
          if (other_req) begin
            state_nx = DEAD;
            gnt_nx   = '1;
          end else if (!REQ[owner_q] && !gnt_q[owner_q]) begin
            state_nx = GRANT;
            timer_nx = '0;
          end else begin
            state_nx = IDLE;
            gnt_nx   = '1;
          end
        end else if (other_req) begin
          // Owner finishes its current transaction without GNT.
          gnt_nx = '1;
        end
      end
      default: begin
        state_nx = IDLE;
        gnt_nx   = '1;
      end
    endcase
  end

  // State and registered outputs; reset forces every grant off immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      gnt_q   <= '1;
      owner_q <= '0;
      rr_q    <= '0;
      timer_q <= '0;
      tev_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      gnt_q   <= gnt_nx;
      owner_q <= owner_nx;
      rr_q    <= rr_nx;
      timer_q <= timer_nx;
      tev_q   <= tev_nx;
    end
  end

  assign GNT        = gnt_q;
  assign OWNER      = owner_q;
  assign OWNER_VLD  = ~&gnt_q;
  assign TIMEOUT_EV = tev_q;
  assign dbg_state  = state_q;

endmodule
